// File: rtl/i_cache_lite.sv
// Direct-mapped instruction cache: synchronous tag/data arrays, flop valid bits,
// single outstanding line fill with flush deferral during an active refill.
module i_cache_lite #(
   parameter int unsigned ADDR_WIDTH = 26,
   parameter int unsigned INDEX_BITS = 5,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] i_pc_next,
   input  logic [ADDR_WIDTH-1:0] i_pc_current,
   input  logic                  i_flush,
   output logic [31:0]           o_instr,
   output logic                  o_valid,
   output logic                  o_miss,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_gnt,
   input  logic                  i_mem_rvalid,
   input  logic [31:0]           i_mem_rdata
);

   localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
   localparam int unsigned IDX_LSB  = OFF_BITS + 2;
   localparam int unsigned TAG_LSB  = IDX_LSB + INDEX_BITS;
   localparam int unsigned TAG_BITS = ADDR_WIDTH - TAG_LSB;
   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam int unsigned WORDS    = LINES * LINE_WORDS;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

   state_t                  r_state;
   logic [LINES-1:0]        r_valid;
   logic [OFF_BITS-1:0]     r_beat_cnt;
   logic                    r_flush_pending;
   logic                    r_mem_req;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic                    r_rd_ok;

   logic [TAG_BITS-1:0]     r_tag_mem [LINES];
   logic [31:0]             r_data_mem [WORDS];
   logic [TAG_BITS-1:0]     r_tag_q;
   logic [31:0]             r_data_q;

   logic [INDEX_BITS-1:0]   w_cur_idx;
   logic [OFF_BITS-1:0]     w_cur_off;
   logic [TAG_BITS-1:0]     w_cur_tag;
   logic [INDEX_BITS-1:0]   w_rd_idx;
   logic [OFF_BITS-1:0]     w_rd_off;
   logic [INDEX_BITS-1:0]   w_fill_idx;
   logic [TAG_BITS-1:0]     w_fill_tag;
   logic [ADDR_WIDTH-1:0]   w_line_addr;
   logic                    w_hit;
   logic                    w_idle_miss;
   logic                    w_last_beat;
   logic                    w_fill_flush;
   logic                    w_unused;

   assign w_cur_idx   = i_pc_current[IDX_LSB +: INDEX_BITS];
   assign w_cur_off   = i_pc_current[2 +: OFF_BITS];
   assign w_cur_tag   = i_pc_current[TAG_LSB +: TAG_BITS];
   assign w_rd_idx    = (r_state == S_IDLE) ? i_pc_next[IDX_LSB +: INDEX_BITS] : w_cur_idx;
   assign w_rd_off    = (r_state == S_IDLE) ? i_pc_next[2 +: OFF_BITS] : w_cur_off;
   assign w_fill_idx  = r_mem_addr[IDX_LSB +: INDEX_BITS];
   assign w_fill_tag  = r_mem_addr[TAG_LSB +: TAG_BITS];
   assign w_line_addr = {i_pc_current[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
   assign w_last_beat = (r_beat_cnt == OFF_BITS'(LINE_WORDS - 1));
   assign w_fill_flush = r_flush_pending | i_flush;
   assign w_unused    = ^{i_pc_next[1:0], i_pc_next[ADDR_WIDTH-1:TAG_LSB], i_pc_current[1:0]};

   // r_rd_ok masks the first cycle after reset, before the array output register holds a real read
   assign w_hit       = r_rd_ok && (r_state == S_IDLE) && !i_flush &&
                        r_valid[w_cur_idx] && (r_tag_q == w_cur_tag);
   assign w_idle_miss = r_rd_ok && (r_state == S_IDLE) && !w_hit;

   assign o_valid    = w_hit;
   assign o_miss     = w_idle_miss || (r_state != S_IDLE);
   assign o_instr    = w_hit ? r_data_q : 32'd0;
   assign o_mem_req  = r_mem_req;
   assign o_mem_addr = r_mem_addr;

   // Tag/data arrays: fill writes plus one synchronous read per cycle
   always_ff @(posedge clk) begin
      if ((r_state == S_FILL) && i_mem_rvalid) begin
         r_data_mem[{w_fill_idx, r_beat_cnt}] <= i_mem_rdata;
         if (w_last_beat)
            r_tag_mem[w_fill_idx] <= w_fill_tag;
      end
      r_tag_q  <= r_tag_mem[w_rd_idx];
      r_data_q <= r_data_mem[{w_rd_idx, w_rd_off}];
   end

   // Miss handling FSM with registered request and line address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_valid         <= '0;
         r_beat_cnt      <= '0;
         r_flush_pending <= 1'b0;
         r_mem_req       <= 1'b0;
         r_mem_addr      <= '0;
         r_rd_ok         <= 1'b0;
      end else begin
         r_rd_ok <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (i_flush)
                  r_valid <= '0;
               if (w_idle_miss) begin
                  r_state         <= S_REQ;
                  r_mem_req       <= 1'b1;
                  r_mem_addr      <= w_line_addr;
                  r_beat_cnt      <= '0;
                  r_flush_pending <= 1'b0;
               end
            end
            S_REQ: begin
               if (i_flush)
                  r_flush_pending <= 1'b1;
               if (i_mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_FILL;
               end
            end
            S_FILL: begin
               if (i_flush)
                  r_flush_pending <= 1'b1;
               if (i_mem_rvalid) begin
                  r_beat_cnt <= OFF_BITS'(r_beat_cnt + 1'b1);
                  if (w_last_beat) begin
                     r_state         <= S_DONE;
                     r_flush_pending <= 1'b0;
                     if (w_fill_flush)
                        r_valid <= '0;
                     else
                        r_valid[w_fill_idx] <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (i_flush)
                  r_valid <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i_cache_lite.sv
// Randomized fetch-stream bench for i_cache_lite against a line-level cache model
// with a deterministic backing memory and a bench-driven memory responder.
module tb_i_cache_lite;

   localparam int unsigned AW = 26;
   localparam int unsigned NR = 120;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] pc_cur;
   logic [AW-1:0] pc_plan;
   logic [AW-1:0] pc_next;
   logic          i_flush;
   logic [31:0]   o_instr;
   logic          o_valid;
   logic          o_miss;
   logic          o_mem_req;
   logic [AW-1:0] o_mem_addr;
   logic          i_mem_gnt;
   logic          i_mem_rvalid;
   logic [31:0]   i_mem_rdata;

   int            n_vec = 0;
   int            n_err = 0;
   bit            m_valid [32];
   logic [16:0]   m_tag   [32];
   logic [AW-1:0] seqa    [NR];

   always #5 clk = ~clk;

   // Fetch stage: advance only when the cache delivers an instruction
   assign pc_next = o_valid ? pc_plan : pc_cur;

   i_cache_lite dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_pc_next    (pc_next),
      .i_pc_current (pc_cur),
      .i_flush      (i_flush),
      .o_instr      (o_instr),
      .o_valid      (o_valid),
      .o_miss       (o_miss),
      .o_mem_req    (o_mem_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_gnt    (i_mem_gnt),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] memw(input logic [AW-1:0] a);
      if (a[AW-1:4] == 22'd4)
         return 32'hA0 + 32'(a[3:2]);
      return {a[25:2], 8'h5C} ^ 32'h3C5A_9E11;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
   endtask

   task automatic step();
      logic [AW-1:0] nx;
      nx = pc_next;
      @(posedge clk);
      #1;
      pc_cur = nx;
   endtask

   // One fetch of address a (already on pc_cur); gdel = grant delay, fbeat = flush beat (9 = in REQ, -1 none)
   task automatic fetch_one(input logic [AW-1:0] a, input logic [AW-1:0] plan,
                            input bit fl_first, input int gdel, input int fbeat);
      int            idx;
      int            b;
      int            fb;
      int            gd;
      bit            flushed;
      bit            done_f;
      logic [AW-1:0] la;
      idx     = int'(a[8:4]);
      la      = {a[AW-1:4], 4'b0000};
      fb      = fbeat;
      gd      = gdel;
      done_f  = 1'b0;
      pc_plan = plan;
      i_flush = fl_first;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = $urandom;
      @(negedge clk);
      if (fl_first) model_clear();
      for (int tries = 0; tries < 3 && !done_f; tries++) begin
         if (m_valid[idx] && (m_tag[idx] == a[25:9])) begin
            chk("hit_valid", 32'(o_valid), 32'd1);
            chk("hit_miss", 32'(o_miss), 32'd0);
            chk("hit_instr", o_instr, memw(a));
            chk("hit_req", 32'(o_mem_req), 32'd0);
            done_f = 1'b1;
            step();
         end else begin
            chk("miss_flags", 32'({o_miss, o_valid}), 32'd2);
            flushed = 1'b0;
            step();
            for (int k = 0; k <= gd; k++) begin
               i_flush      = (fb == 9) && (k == 0);
               i_mem_gnt    = (k == gd);
               i_mem_rvalid = 1'($urandom);
               i_mem_rdata  = $urandom;
               if (i_flush) flushed = 1'b1;
               @(negedge clk);
               chk("req_on", 32'(o_mem_req), 32'd1);
               chk("req_addr", 32'(o_mem_addr), 32'(la));
               chk("req_stall", 32'({o_miss, o_valid}), 32'd2);
               step();
            end
            i_mem_gnt = 1'b0;
            b = 0;
            for (int c = 0; c < 200 && b < 4; c++) begin
               i_mem_rvalid = (c >= 20) || ($urandom_range(0, 1) == 1);
               i_mem_rdata  = i_mem_rvalid ? memw(la + AW'(4 * b)) : $urandom;
               i_flush      = i_mem_rvalid && (b == fb) && !flushed;
               if (i_flush) flushed = 1'b1;
               @(negedge clk);
               chk("fill_req", 32'(o_mem_req), 32'd0);
               chk("fill_stall", 32'({o_miss, o_valid}), 32'd2);
               step();
               if (i_mem_rvalid) b++;
            end
            i_flush      = 1'b0;
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = $urandom;
            @(negedge clk);
            chk("done_stall", 32'({o_miss, o_valid}), 32'd2);
            m_tag[idx] = a[25:9];
            if (flushed) model_clear();
            else m_valid[idx] = 1'b1;
            step();
            i_mem_rvalid = 1'b0;
            fb = -1;
            gd = $urandom_range(0, 2);
            @(negedge clk);
         end
      end
      if (!done_f) chk("fetch_done", 32'(o_valid), 32'd1);
      i_flush      = 1'b0;
      i_mem_rvalid = 1'b0;
   endtask

   initial begin
      int r;
      int fb;
      rst_n        = 1'b0;
      pc_cur       = 26'h40;
      pc_plan      = 26'h44;
      i_flush      = 1'b0;
      i_mem_gnt    = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      model_clear();
      for (int i = 0; i < 32; i++) m_tag[i] = '0;

      // Address stream for the random phase; last entry returns to line 0x40
      seqa[0] = 26'h100;
      for (int i = 1; i < int'(NR); i++) begin
         if ($urandom_range(0, 2) == 0)
            seqa[i] = seqa[i-1] + 26'd4;
         else
            seqa[i] = {15'd0, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'b00};
      end
      seqa[NR-1] = 26'h40;

      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_miss", 32'(o_miss), 32'd0);
      chk("rst_req", 32'(o_mem_req), 32'd0);
      chk("rst_addr", 32'(o_mem_addr), 32'd0);
      chk("rst_instr", o_instr, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      fetch_one(26'h040, 26'h044, 1'b0, 0, -1);
      fetch_one(26'h044, 26'h048, 1'b0, 0, -1);
      fetch_one(26'h048, 26'h04C, 1'b0, 0, -1);
      fetch_one(26'h04C, 26'h240, 1'b0, 0, -1);
      fetch_one(26'h240, 26'h040, 1'b0, 1, -1);
      fetch_one(26'h040, 26'h080, 1'b0, 0, -1);
      fetch_one(26'h080, 26'h0C0, 1'b0, 0, 2);
      fetch_one(26'h0C0, 26'h0C4, 1'b0, 5, -1);
      fetch_one(26'h0C4, seqa[0], 1'b1, 0, -1);

      for (int i = 0; i < int'(NR) - 1; i++) begin
         r  = $urandom_range(0, 9);
         fb = (r < 4) ? r : ((r == 4) ? 9 : -1);
         fetch_one(seqa[i], seqa[i+1], ($urandom_range(0, 19) == 0), $urandom_range(0, 3), fb);
      end

      // Reset in the middle of a fill of line 0x40
      i_flush      = 1'b1;
      i_mem_rvalid = 1'b0;
      @(negedge clk);
      chk("rf_miss", 32'({o_miss, o_valid}), 32'd2);
      model_clear();
      step();
      i_flush   = 1'b0;
      i_mem_gnt = 1'b1;
      @(negedge clk);
      chk("rf_req", 32'(o_mem_req), 32'd1);
      step();
      i_mem_gnt = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_mem_rvalid = 1'b1;
         i_mem_rdata  = 32'hDEAD_0000 + 32'(k);
         @(negedge clk);
         chk("rf_fill", 32'({o_miss, o_mem_req}), 32'd2);
         step();
      end
      i_mem_rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rf_rst_req", 32'(o_mem_req), 32'd0);
      chk("rf_rst_miss", 32'(o_miss), 32'd0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hBAD0_0001;
      @(negedge clk);
      chk("rf_stray_req", 32'(o_mem_req), 32'd0);
      step();
      fetch_one(26'h040, 26'h044, 1'b0, 0, -1);
      fetch_one(26'h044, 26'h048, 1'b0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
